// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the 8-way round-robin grant controller.
// Holds the FSM state encoding and the rotating-priority search.
package rr_grant_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // First set bit of req searching ptr, ptr+1, ... modulo N_REQ.
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic             hit;
    next_rr = ptr;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!hit && req[idx]) begin
        next_rr = idx;
        hit     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_grant_ctrl8_if.sv
// Request/grant bundle between requesters and the grant controller.
// master = requester side, slave = arbiter side.
interface rr_grant_ctrl8_if;
  import rr_grant_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );

endinterface

// File: rtl/decoder3_8.sv
// 3-to-8 binary to one-hot decoder.
// Pure combinational.
module decoder3_8 (
  input  logic [2:0] a,
  output logic [7:0] y
);

  assign y = 8'b1 << a;

endmodule

// File: rtl/rr_grant_ctrl8.sv
// Round-robin owner sequencing for one 8-slot shared resource.
// One IDLE bubble per hand-over; hold time bounded by HOLD_MAX.
module rr_grant_ctrl8
  import rr_grant_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_grant_ctrl8_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pre, pre_nx;
  logic [N_REQ-1:0] dec_y;
  logic             rel_done;
  logic             rel_drop;
  logic             rel_to;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (HOLD_MAX >= 1 && HOLD_MAX <= 255)
        else $error("rr_grant_ctrl8: HOLD_MAX=%0d illegal", HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      cnt   <= '0;
      pre   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      pre   <= pre_nx;
    end
  end

  assign rel_done = bus.done;
  assign rel_drop = !bus.req[idx];
  assign rel_to   = (cnt == HOLD_LAST);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    cnt_nx   = cnt;
    pre_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          idx_nx   = next_rr(bus.req, ptr);
          cnt_nx   = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_to) begin
          state_nx = IDLE;
          ptr_nx   = idx + IDX_W'(1);
          // Timeout only counts as preemption when nothing else released.
          pre_nx   = rel_to && !rel_done && !rel_drop;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  decoder3_8 u_dec (
    .a (idx),
    .y (dec_y)
  );

  assign bus.gnt_valid = (state == GRANT);
  assign bus.gnt_idx   = idx;
  assign bus.preempt   = pre;
  assign bus.gnt       = dec_y & {N_REQ{bus.gnt_valid}};

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed bench for rr_grant_ctrl8.
// Two instances: HOLD_MAX=8 (a) and HOLD_MAX=3 (b).
module tb_rr_grant_ctrl8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_grant_ctrl8_if a_if ();
  rr_grant_ctrl8_if b_if ();

  rr_grant_ctrl8 #(.HOLD_MAX(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  rr_grant_ctrl8 #(.HOLD_MAX(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag,
                       input logic [7:0] g,
                       input logic [2:0] i,
                       input logic v,
                       input logic p);
    chk({tag, ".gnt"}, 32'(a_if.gnt), 32'(g));
    chk({tag, ".idx"}, 32'(a_if.gnt_idx), 32'(i));
    chk({tag, ".vld"}, 32'(a_if.gnt_valid), 32'(v));
    chk({tag, ".pre"}, 32'(a_if.preempt), 32'(p));
  endtask

  task automatic chk_b(input string tag,
                       input logic [7:0] g,
                       input logic v,
                       input logic p);
    chk({tag, ".gnt"}, 32'(b_if.gnt), 32'(g));
    chk({tag, ".vld"}, 32'(b_if.gnt_valid), 32'(v));
    chk({tag, ".pre"}, 32'(b_if.preempt), 32'(p));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_if.req = '0;
    a_if.done = 1'b0;
    b_if.req = '0;
    b_if.done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_a("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    chk_b("rst_b", 8'h00, 1'b0, 1'b0);

    // T1: single requester held past HOLD_MAX
    a_if.req = 8'h04;
    tick();
    chk_a("t1_g1", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    chk_a("t1_g8", 8'h04, 3'd2, 1'b1, 1'b0);
    tick();
    chk_a("t1_to", 8'h00, 3'd2, 1'b0, 1'b1);
    tick();
    chk_a("t1_re", 8'h04, 3'd2, 1'b1, 1'b0);
    a_if.req = 8'h00;
    tick();
    chk_a("t1_rel", 8'h00, 3'd2, 1'b0, 1'b0);

    // T3: ptr=3, search wraps to 0
    a_if.req = 8'h05;
    tick();
    chk_a("t3_wrap", 8'h01, 3'd0, 1'b1, 1'b0);
    a_if.done = 1'b1;
    tick();
    a_if.done = 1'b0;
    a_if.req = 8'h00;
    chk_a("t3_rel", 8'h00, 3'd0, 1'b0, 1'b0);

    // T2: full request, done on each first grant cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_if.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_a($sformatf("t2_g%0d", k), 8'(1 << (k % 8)),
            3'(k % 8), 1'b1, 1'b0);
      a_if.done = 1'b1;
      tick();
      a_if.done = 1'b0;
      chk_a($sformatf("t2_b%0d", k), 8'h00, 3'(k % 8),
            1'b0, 1'b0);
    end

    // T4: owner 5 drops its request in grant cycle 2
    a_if.req = 8'h20;
    tick();
    chk_a("t4_g1", 8'h20, 3'd5, 1'b1, 1'b0);
    tick();
    chk_a("t4_g2", 8'h20, 3'd5, 1'b1, 1'b0);
    a_if.req = 8'h00;
    tick();
    chk_a("t4_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    a_if.req = 8'h41;
    tick();
    chk_a("t4_ptr6", 8'h40, 3'd6, 1'b1, 1'b0);
    a_if.req = 8'h00;
    tick();
    chk_a("t4_rel2", 8'h00, 3'd6, 1'b0, 1'b0);

    // T5: done while idle is ignored
    a_if.done = 1'b1;
    tick();
    chk_a("t5_idle1", 8'h00, 3'd6, 1'b0, 1'b0);
    tick();
    chk_a("t5_idle2", 8'h00, 3'd6, 1'b0, 1'b0);
    a_if.done = 1'b0;

    // T5b: HOLD_MAX=3, done coincides with timeout
    b_if.req = 8'h08;
    tick();
    chk_b("t5_b_g1", 8'h08, 1'b1, 1'b0);
    tick();
    chk_b("t5_b_g2", 8'h08, 1'b1, 1'b0);
    tick();
    chk_b("t5_b_g3", 8'h08, 1'b1, 1'b0);
    b_if.done = 1'b1;
    tick();
    b_if.done = 1'b0;
    chk_b("t5_b_rel", 8'h00, 1'b0, 1'b0);
    tick();
    chk_b("t5_b_re", 8'h08, 1'b1, 1'b0);
    tick();
    tick();
    chk_b("t5_b_g3b", 8'h08, 1'b1, 1'b0);
    tick();
    chk_b("t5_b_to", 8'h00, 1'b0, 1'b1);
    tick();
    chk_b("t5_b_pls", 8'h08, 1'b1, 1'b0);
    b_if.req = 8'h00;

    // T6: reset during grant of idx 4
    a_if.req = 8'h10;
    tick();
    chk_a("t6_g1", 8'h10, 3'd4, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a("t6_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    a_if.req = 8'h90;
    tick();
    chk_a("t6_ptr0", 8'h10, 3'd4, 1'b1, 1'b0);
    a_if.req = 8'h00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl8.md
Name: rr_grant_ctrl8

Overview:
- Round-robin arbiter/scheduler that shares one 8-way resource between eight requesters.
- The winning 3-bit index drives the existing decoder3_8, which produces the one-hot grant vector.
- Sits in front of any 8-slot shared resource (bus, memory port, output line) and sequences ownership with a bounded hold time.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255. 0 is illegal and must be flagged by a simulation-time check.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  8  request vector, bit i = requester i wants the resource (level, held while wanted)
done  input  1  owner releases the resource this cycle; ignored unless gnt_valid=1
gnt  output  8  one-hot grant, driven by decoder3_8 from gnt_idx and gated by gnt_valid; all-zero when idle
gnt_idx  output  3  index of current owner; valid only when gnt_valid=1
gnt_valid  output  1  a grant is active
preempt  output  1  one-cycle pulse: the grant was removed by hold timeout

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0. rst overrides everything, including a mid-grant state; there is no partial release and no preempt pulse.
- State: 2-state FSM (IDLE, GRANT), 3-bit priority pointer ptr, 8-bit hold_cnt.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, ..., ptr+7, modulo 8.
  - At the next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency from req sampled to gnt visible is 1 cycle.
  - If req==0, remain in IDLE. done is ignored.
- GRANT: the release condition is evaluated every cycle:
  - (a) done=1, or
  - (b) req[gnt_idx]=0, or
  - (c) hold_cnt==HOLD_MAX-1.
- On release at an edge: gnt_valid=0, gnt=0, ptr=(gnt_idx+1) mod 8 (wraps 7->0), go to IDLE.
  - preempt=1 for that one cycle only if (c) holds and (a) and (b) are both false.
- Without release, hold_cnt increments. As a result, gnt is visible for at most HOLD_MAX cycles.
- There is always exactly one IDLE bubble cycle between consecutive grants, even when other requests are pending. Arbitration happens in that bubble.
- Changes to req bits other than the owner's have no effect during GRANT.
- Simultaneous events:
  - done together with timeout counts as a normal release (preempt=0).
  - A new req arriving during the release cycle is considered in the following IDLE cycle.
- gnt must always be zero or one-hot. gnt_idx holds its last value while gnt_valid=0.
- All outputs are registered except gnt, which is decoder3_8(gnt_idx) ANDed with {8{gnt_valid}}.

Decomposition:
- Package rr_grant_pkg:
  - state enum {IDLE, GRANT}
  - constants N_REQ=8, IDX_W=3, CNT_W=8
  - function next_rr(req, ptr) returning winner index
- Sub-module: reuse the existing decoder3_8 (ports a, y) for the index-to-one-hot conversion. No other sub-modules.

Test Plan:
1. Reset, then req=8'b0000_0100 held, done=0, HOLD_MAX=8 -> one cycle later gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1. Held for 8 cycles, then a preempt pulse and gnt=0. Next grant (after one bubble) goes back to idx 2.
2. req=8'hFF held, done pulsed on each grant's first cycle -> grant order 0,1,2,3,4,5,6,7,0. Each grant lasts 1 cycle, separated by 1 IDLE cycle; ptr wraps 7->0.
3. After a grant to idx 2 is released (ptr=3), apply req=8'b0000_0101 -> winner idx 0 (search 3..7 empty, wraps to 0), gnt=8'b0000_0001.
4. Owner idx 5 drops req[5] in grant cycle 2 with no done -> release at that edge, preempt stays 0, ptr=6.
5. done pulsed while IDLE with req=0 -> no state change, all outputs 0. done pulsed with timeout on the same cycle (HOLD_MAX=3, third cycle) -> release with preempt=0.
6. rst asserted during GRANT of idx 4 -> next cycle gnt=0, gnt_valid=0, preempt=0, ptr=0. With req=8'b1001_0000 after reset, the winner is idx 4 (searching from 0).
